// File: rtl/instr_mem_loader.sv
// Streams little-endian bytes into 32-bit words and writes them to consecutive
// instruction-memory word addresses. Start/Abort/Done/Error sequencing, all outputs registered.
//
// state   | meaning
// IDLE    | waiting for an accepted Start
// COLLECT | accepting bytes 0..3 of the current word
// WRITE   | one-cycle memory write of the assembled word
// FINISH  | one-cycle Done pulse, then back to IDLE
module instr_mem_loader #(
  parameter int ADDR_WIDTH = 10,
  parameter int DEPTH      = 1024
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] start_address,
  input  logic [ADDR_WIDTH:0]   word_count,
  input  logic                  abort,
  input  logic [7:0]            byte_in,
  input  logic                  byte_valid,
  output logic                  byte_ready,
  output logic                  mem_write_enable,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [31:0]           mem_write_data,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [ADDR_WIDTH:0]   words_written
);

  localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH + 1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, COLLECT, WRITE, FINISH} state_t;

  state_t              state, state_nxt;
  logic [1:0]          byte_idx;
  logic [23:0]         asm_lo;
  logic [ADDR_WIDTH:0] count;
  logic                accept, count_ok, start_ok, start_bad, abort_hit, last_word;

  always_comb begin
    accept    = byte_ready && byte_valid;
    count_ok  = (word_count != '0) && (word_count <= DEPTH_W);
    start_ok  = (state == IDLE) && start && count_ok;
    start_bad = (state == IDLE) && start && !count_ok;
    abort_hit = abort && ((state == COLLECT) || (state == WRITE));
    last_word = ((words_written + 1'b1) == count);
    state_nxt = state;
    case (state)
      IDLE:    if (start_ok) state_nxt = COLLECT;
      COLLECT: begin
        if (abort)                           state_nxt = IDLE;
        else if (accept && byte_idx == 2'd3) state_nxt = WRITE;
      end
      // An abort during WRITE still lets this word land, but suppresses Done.
      WRITE: begin
        if (abort)          state_nxt = IDLE;
        else if (last_word) state_nxt = FINISH;
        else                state_nxt = COLLECT;
      end
      FINISH:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= IDLE;
      byte_ready       <= 1'b0;
      mem_write_enable <= 1'b0;
      mem_address      <= '0;
      mem_write_data   <= '0;
      busy             <= 1'b0;
      done             <= 1'b0;
      error            <= 1'b0;
      words_written    <= '0;
      byte_idx         <= '0;
      asm_lo           <= '0;
      count            <= '0;
    end else begin
      state            <= state_nxt;
      byte_ready       <= (state_nxt == COLLECT);
      mem_write_enable <= (state_nxt == WRITE);
      busy             <= (state_nxt != IDLE);
      done             <= (state_nxt == FINISH);
      error            <= start_bad || abort_hit;

      if (start_ok) begin
        count         <= word_count;
        words_written <= '0;
        byte_idx      <= '0;
        mem_address   <= start_address;
      end

      if (state == COLLECT) begin
        if (abort) begin
          byte_idx <= '0;
        end else if (accept) begin
          byte_idx <= byte_idx + 1'b1;
          case (byte_idx)
            2'd0:    asm_lo[7:0]   <= byte_in;
            2'd1:    asm_lo[15:8]  <= byte_in;
            2'd2:    asm_lo[23:16] <= byte_in;
            default: mem_write_data <= {byte_in, asm_lo};
          endcase
        end
      end

      // Address wraps naturally because DEPTH is 2**ADDR_WIDTH.
      if (state == WRITE) begin
        mem_address   <= mem_address + 1'b1;
        words_written <= words_written + 1'b1;
      end
    end
  end

endmodule
